count_binary_led_pwm: RTL and testbench



---
 rtl/count_binary_led_pwm_if.sv | 19 +
 rtl/count_binary_led_pwm.sv | 114 +++++++++++
 tb/tb_count_binary_led_pwm.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/count_binary_led_pwm_if.sv
// Avalon-MM slave bus for the LED brightness/blink stage: register select,
// write strobe, write data and zero-wait-state read data.
interface count_binary_led_pwm_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/count_binary_led_pwm.sv
// LED brightness and blink stage: latches the PIO pattern at PWM frame
// boundaries and gates it with a programmable duty and a blink envelope.
module count_binary_led_pwm #(
    parameter int LED_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    count_binary_led_pwm_if.slave bus,
    input  logic [LED_WIDTH-1:0] pattern_in,
    output logic [LED_WIDTH-1:0] led_out
);

    logic                 enable;
    logic                 blink_en;
    logic [8:0]           duty_reg;
    logic [8:0]           duty_act;
    logic [15:0]          prescale;
    logic [7:0]           pwm_cnt;
    logic [15:0]          frame_cnt;
    logic                 blink_phase;
    logic [LED_WIDTH-1:0] latched;
    logic [7:0]           status_pat;

    logic                 wr;
    logic                 wr_ctrl;
    logic                 wr_duty;
    logic                 wr_prescale;
    logic [8:0]           duty_wr;
    logic                 frame_wrap;
    logic                 pwm_on;

    assign wr          = bus.chipselect & ~bus.write_n;
    assign wr_ctrl     = wr && (bus.address == 2'd0);
    assign wr_duty     = wr && (bus.address == 2'd1);
    assign wr_prescale = wr && (bus.address == 2'd2);
    assign duty_wr     = (bus.writedata > 32'd256) ? 9'd256 : bus.writedata[8:0];

    assign frame_wrap  = enable && (pwm_cnt == 8'hFF);
    assign pwm_on      = ({1'b0, pwm_cnt} < duty_act);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable   <= 1'b0;
            blink_en <= 1'b0;
            duty_reg <= 9'd256;
            prescale <= 16'd0;
        end else begin
            if (wr_ctrl) begin
                enable   <= bus.writedata[0];
                blink_en <= bus.writedata[1];
            end
            if (wr_duty)
                duty_reg <= duty_wr;
            if (wr_prescale)
                prescale <= bus.writedata[15:0];
        end
    end

    // Duty and pattern only change at frame boundaries so a frame never mixes values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_cnt  <= 8'd0;
            duty_act <= 9'd256;
            latched  <= '0;
            led_out  <= '0;
        end else begin
            pwm_cnt <= enable ? pwm_cnt + 8'd1 : 8'd0;
            if (!enable || frame_wrap) begin
                duty_act <= duty_reg;
                latched  <= pattern_in;
            end
            led_out <= enable ? (latched & {LED_WIDTH{pwm_on & blink_phase}}) : '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt   <= 16'd0;
            blink_phase <= 1'b1;
        end else if (!blink_en) begin
            frame_cnt   <= 16'd0;
            blink_phase <= 1'b1;
        end else if (wr_prescale) begin
            frame_cnt <= 16'd0;
        end else if (frame_wrap) begin
            if (frame_cnt == prescale) begin
                frame_cnt   <= 16'd0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    generate
        if (LED_WIDTH >= 8) begin : g_status_trunc
            assign status_pat = latched[7:0];
        end else begin : g_status_ext
            assign status_pat = {{(8 - LED_WIDTH){1'b0}}, latched};
        end
    endgenerate

    always_comb begin
        bus.readdata = 32'd0;
        case (bus.address)
            2'd0: bus.readdata = {30'd0, blink_en, enable};
            2'd1: bus.readdata = {23'd0, duty_reg};
            2'd2: bus.readdata = {16'd0, prescale};
            2'd3: bus.readdata = {15'd0, enable, status_pat, 7'd0, blink_phase};
            default: bus.readdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_count_binary_led_pwm.sv
// Directed bench for count_binary_led_pwm: register table plus hand-timed
// PWM, pattern-latch, blink, reset and disable sequences.
module tb_count_binary_led_pwm;

    logic       clk;
    logic       reset_n;
    logic [7:0] pattern_in;
    logic [7:0] led_out;
    int         tests_run;
    int         tests_failed;
    int         cyc;
    int         t0;

    count_binary_led_pwm_if bus();

    count_binary_led_pwm #(.LED_WIDTH(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .pattern_in (pattern_in),
        .led_out    (led_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } reg_vec_t;

    reg_vec_t vecs[9];

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.writedata  = d;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic read_check(input string name, input logic [1:0] a, input logic [31:0] exp);
        bus.address = a;
        #1;
        tests_run++;
        if (bus.readdata !== exp) begin
            tests_failed++;
            $display("FAIL %s: readdata got %h expected %h", name, bus.readdata, exp);
        end
    endtask

    task automatic check_led(input string name, input logic [7:0] exp);
        tests_run++;
        if (led_out !== exp) begin
            tests_failed++;
            $display("FAIL %s: led_out got %h expected %h", name, led_out, exp);
        end
    endtask

    task automatic wait_n(input int n);
        while ((cyc - t0) < n) @(negedge clk);
    endtask

    // n counts clock edges since the enabling CONTROL write; led_out after
    // edge n reflects pwm_cnt = (n-1) mod 256.
    task automatic check_wave(input string name, input int n_from, input int n_to,
                              input int duty_a, input int duty_b, input int d_sw,
                              input logic [7:0] pat_a, input logic [7:0] pat_b,
                              input int p_sw, input int blink_frames);
        int         bad;
        int         n_bad;
        logic [7:0] e;
        logic [7:0] e_bad;
        logic [7:0] g_bad;
        int         c;
        int         d;
        logic       on;
        bad   = 0;
        n_bad = 0;
        e_bad = 8'h00;
        g_bad = 8'h00;
        for (int n = n_from; n <= n_to; n++) begin
            wait_n(n);
            c  = (n - 1) % 256;
            d  = (n >= d_sw) ? duty_b : duty_a;
            on = (c < d);
            if (blink_frames > 0 && (((n - 1) / (256 * blink_frames)) % 2) != 0)
                on = 1'b0;
            e = on ? ((n >= p_sw) ? pat_b : pat_a) : 8'h00;
            if (led_out !== e) begin
                if (bad == 0) begin
                    n_bad = n;
                    e_bad = e;
                    g_bad = led_out;
                end
                bad++;
            end
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL %s: at n=%0d led_out got %h expected %h (%0d bad samples)",
                     name, n_bad, g_bad, e_bad, bad);
        end
    endtask

    task automatic restart(input int duty);
        bus_write(2'd0, 32'd0);
        bus_write(2'd1, duty);
        bus_write(2'd0, 32'd1);
        t0 = cyc;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tests_run      = 0;
        tests_failed   = 0;
        t0             = 0;
        reset_n        = 1'b0;
        pattern_in     = 8'h00;
        bus.address    = 2'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 32'd0;

        vecs[0] = '{2'd1, 32'd300,        32'd256};
        vecs[1] = '{2'd1, 32'd0,          32'd0};
        vecs[2] = '{2'd1, 32'd257,        32'd256};
        vecs[3] = '{2'd1, 32'd255,        32'd255};
        vecs[4] = '{2'd1, 32'd256,        32'd256};
        vecs[5] = '{2'd2, 32'h0001_2345,  32'h0000_2345};
        vecs[6] = '{2'd0, 32'hFFFF_FFFC,  32'd0};
        vecs[7] = '{2'd0, 32'd2,          32'd2};
        vecs[8] = '{2'd3, 32'hFFFF_FFFF,  32'h0000_0001};

        #25;
        check_led("reset_led", 8'h00);
        read_check("reset_control",  2'd0, 32'd0);
        read_check("reset_duty",     2'd1, 32'd256);
        read_check("reset_prescale", 2'd2, 32'd0);
        read_check("reset_status",   2'd3, 32'h0000_0001);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            bus_write(vecs[i].addr, vecs[i].wdata);
            read_check($sformatf("regvec%0d", i), vecs[i].addr, vecs[i].exp);
        end
        bus_write(2'd0, 32'd0);

        pattern_in = 8'hA5;
        restart(128);
        check_wave("duty128", 1, 512, 128, 128, 0, 8'hA5, 8'hA5, 0, 0);
        read_check("status_enabled", 2'd3, 32'h0001_A501);

        wait_n(562);
        pattern_in = 8'h0F;
        check_wave("pattern_frame_latch", 563, 1100, 128, 128, 0, 8'hA5, 8'h0F, 769, 0);

        pattern_in = 8'hA5;
        restart(0);
        check_wave("duty0", 1, 520, 0, 0, 0, 8'hA5, 8'hA5, 0, 0);

        restart(256);
        check_wave("duty256", 1, 100, 256, 256, 0, 8'hA5, 8'hA5, 0, 0);
        bus_write(2'd1, 32'd0);
        check_wave("duty_shadow", 102, 600, 256, 0, 257, 8'hA5, 8'hA5, 0, 0);

        bus_write(2'd0, 32'd0);
        bus_write(2'd2, 32'd2);
        bus_write(2'd1, 32'd256);
        bus_write(2'd0, 32'd3);
        t0 = cyc;
        check_wave("blink_a", 1, 700, 256, 256, 0, 8'hA5, 8'hA5, 0, 3);
        read_check("blink_status_on", 2'd3, 32'h0001_A501);
        check_wave("blink_b", 701, 800, 256, 256, 0, 8'hA5, 8'hA5, 0, 3);
        read_check("blink_status_off", 2'd3, 32'h0001_A500);
        check_wave("blink_c", 801, 1700, 256, 256, 0, 8'hA5, 8'hA5, 0, 3);

        restart(256);
        check_wave("pre_reset_lit", 1, 10, 256, 256, 0, 8'hA5, 8'hA5, 0, 0);
        #3;
        reset_n = 1'b0;
        #1;
        check_led("async_reset_led", 8'h00);
        read_check("midreset_control",  2'd0, 32'd0);
        read_check("midreset_duty",     2'd1, 32'd256);
        read_check("midreset_prescale", 2'd2, 32'd0);
        read_check("midreset_status",   2'd3, 32'h0000_0001);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        restart(128);
        check_wave("pre_disable", 1, 40, 128, 128, 0, 8'hA5, 8'hA5, 0, 0);
        bus_write(2'd0, 32'd0);
        read_check("disabled_status", 2'd3, 32'h0000_A501);
        @(negedge clk);
        check_led("disable_dark", 8'h00);
        begin
            int lit;
            lit = 0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (led_out !== 8'h00) lit++;
            end
            tests_run++;
            if (lit != 0) begin
                tests_failed++;
                $display("FAIL disabled_hold: lit samples got %0d expected 0", lit);
            end
        end
        bus_write(2'd0, 32'd1);
        t0 = cyc;
        check_wave("reenable_restart", 1, 300, 128, 128, 0, 8'hA5, 8'hA5, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
